// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: arbiter FSM states and AXI response codes shared by the round-robin arbiter
package axi4_lite_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} arb_state_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi4_lite_rr_arbiter_if.sv
// axi4_lite_rr_arbiter_if: requester, command and response signals of the shared AXI4-Lite arbiter
// master is the arbiter's view (it masters the command bus); slave is the environment's view.
interface axi4_lite_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDRESS-1:0]    req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]          req_wstrb;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            req_done;
    logic [DATA_WIDTH-1:0]         req_rdata;
    logic [1:0]                    req_resp;
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic                          cmd_write;
    logic [ADDRESS-1:0]            cmd_addr;
    logic [DATA_WIDTH-1:0]         cmd_wdata;
    logic [3:0]                    cmd_wstrb;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic [1:0]                    rsp_resp;
    logic                          busy;
    logic                          stray_rsp;
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
        output req_ack, req_done, req_rdata, req_resp, cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
               rsp_ready, busy, stray_rsp
    );
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
        input  req_ack, req_done, req_rdata, req_resp, cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
               rsp_ready, busy, stray_rsp
    );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin picker; grants the first request above ptr, wrapping modulo N
module rr_picker #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic         any
);
    logic [W-1:0] idx;
    // Walk from farthest to nearest so the nearest requester above ptr overwrites the rest.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            idx = W'((int'(ptr) + i) % N);
            if (req[idx]) gnt = N'(1) << idx;
        end
    end
    assign any = |req;
endmodule

// File: rtl/axi4_lite_rr_arbiter.sv
// axi4_lite_rr_arbiter: shares one AXI4-Lite master among NUM_REQ requesters, one transaction at a time
// Round-robin grant, latched command, response routed back to the winner, optional response timeout.
module axi4_lite_rr_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input logic ACLK,
    input logic ARESETN,
    axi4_lite_rr_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d, gnt_idx_q, gnt_idx_d, pick_idx;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [ADDRESS-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  stray_q, stray_d;
    logic [NUM_REQ-1:0]    gnt;
    logic                  any;
    logic                  timeout_hit;
    logic [ADDRESS-1:0]    addr_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
    logic [3:0]            wstrb_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = bus.req_addr[g*ADDRESS +: ADDRESS];
        assign wdata_a[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign wstrb_a[g] = bus.req_wstrb[g*4 +: 4];
    end

    rr_picker #(.N(NUM_REQ)) u_pick (.req(bus.req_valid), .ptr(ptr_q), .gnt(gnt), .any(any));

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) pick_idx = IW'(i);
    end

    assign timeout_hit = TIMEOUT != 0 && int'(cnt_q) == TIMEOUT - 1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        stray_d   = stray_q | (bus.rsp_valid & (state_q != WAIT_RSP));
        if (state_q == IDLE && any) begin
            state_d   = ISSUE;
            gnt_idx_d = pick_idx;
            write_d   = bus.req_write[pick_idx];
            addr_d    = addr_a[pick_idx];
            wdata_d   = wdata_a[pick_idx];
            wstrb_d   = wstrb_a[pick_idx];
        end
        if (state_q == ISSUE && bus.cmd_ready) begin
            state_d = WAIT_RSP;
            cnt_d   = '0;
        end
        if (state_q == WAIT_RSP) begin
            cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
            // A real response in the final timeout cycle still wins over the forced SLVERR.
            if (bus.rsp_valid || timeout_hit) begin
                state_d = IDLE;
                ptr_d   = gnt_idx_q;
                done_d  = NUM_REQ'(1) << gnt_idx_q;
                rdata_d = bus.rsp_valid ? bus.rsp_rdata : '0;
                resp_d  = bus.rsp_valid ? bus.rsp_resp : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NUM_REQ - 1);
            gnt_idx_q <= '0;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            stray_q   <= stray_d;
        end
    end

    // Ack is combinational so a requester learns of its grant in the same cycle; held low in reset.
    assign bus.req_ack   = (ARESETN && state_q == IDLE) ? gnt : '0;
    assign bus.req_done  = done_q;
    assign bus.req_rdata = rdata_q;
    assign bus.req_resp  = resp_q;
    assign bus.cmd_valid = state_q == ISSUE;
    assign bus.cmd_write = write_q;
    assign bus.cmd_addr  = addr_q;
    assign bus.cmd_wdata = wdata_q;
    assign bus.cmd_wstrb = wstrb_q;
    assign bus.rsp_ready = state_q == WAIT_RSP;
    assign bus.busy      = state_q != IDLE;
    assign bus.stray_rsp = stray_q;
endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
// tb_axi4_lite_rr_arbiter: random requesters and master against a transaction-level scoreboard
module tb_axi4_lite_rr_arbiter;
    localparam int NR = 4;
    localparam int TO = 8;

    typedef struct {int who; logic w; logic [31:0] a; logic [31:0] d; logic [3:0] s;} cmd_t;
    typedef struct {int who; logic [31:0] d; logic [1:0] r; int cyc;} done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    axi4_lite_rr_arbiter_if #(.NUM_REQ(NR), .ADDRESS(32), .DATA_WIDTH(32)) bus ();
    axi4_lite_rr_arbiter #(.NUM_REQ(NR), .ADDRESS(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .ACLK(clk), .ARESETN(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, last = NR - 1, rsp_at = -1;
    bit run = 0, gen = 0;
    bit acked [NR];
    logic t_w [NR];
    logic [31:0] t_a [NR], t_d [NR];
    logic [3:0] t_s [NR];
    logic [31:0] r_data;
    logic [1:0] r_resp;
    cmd_t cmd_q[$];
    done_t done_q[$];
    done_t me;
    cmd_t mc;
    int mg, md;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", n, act, req, cyc);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int l);
        for (int k = 1; k <= NR; k++) if (v[(l + k) % NR]) return (l + k) % NR;
        return -1;
    endfunction

    task automatic new_txn(input int i);
        t_w[i] = 1'($urandom);
        t_a[i] = $urandom & 32'hFFFF_FFFC;
        t_d[i] = $urandom;
        t_s[i] = 4'($urandom);
        bus.req_write[i] = t_w[i];
        bus.req_addr[i*32 +: 32] = t_a[i];
        bus.req_wdata[i*32 +: 32] = t_d[i];
        bus.req_wstrb[i*4 +: 4] = t_s[i];
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (acked[i]) begin
                acked[i] = 0;
                bus.req_valid[i] = 1'b0;
            end else if (bus.req_valid[i] && $urandom_range(0, 29) == 0) bus.req_valid[i] = 1'b0;
            else if (!bus.req_valid[i] && gen && $urandom_range(0, 2) == 0) new_txn(i);
        end
        // Periodic 6-cycle stalls exercise command backpressure.
        bus.cmd_ready = ($urandom_range(0, 3) != 0) && (cyc % 40 >= 6);
        bus.rsp_valid = (cyc == rsp_at);
        bus.rsp_rdata = bus.rsp_valid ? r_data : $urandom;
        bus.rsp_resp = bus.rsp_valid ? r_resp : 2'($urandom);
    endtask

    task automatic check_reset(input string n);
        chk({n, "_ack"}, bus.req_ack, 0);
        chk({n, "_done"}, bus.req_done, 0);
        chk({n, "_rdata"}, bus.req_rdata, 0);
        chk({n, "_resp"}, bus.req_resp, 0);
        chk({n, "_cmd_valid"}, bus.cmd_valid, 0);
        chk({n, "_cmd_write"}, bus.cmd_write, 0);
        chk({n, "_cmd_addr"}, bus.cmd_addr, 0);
        chk({n, "_cmd_wdata"}, bus.cmd_wdata, 0);
        chk({n, "_cmd_wstrb"}, bus.cmd_wstrb, 0);
        chk({n, "_rsp_ready"}, bus.rsp_ready, 0);
        chk({n, "_busy"}, bus.busy, 0);
        chk({n, "_stray"}, bus.stray_rsp, 0);
    endtask

    // Monitor: completions, phase flags, command fields, then grant prediction.
    always @(negedge clk) if (run) begin
        if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
            me = done_q.pop_front();
            chk("req_done", bus.req_done, NR'(1) << me.who);
            chk("req_rdata", bus.req_rdata, me.d);
            chk("req_resp", bus.req_resp, me.r);
        end else chk("req_done_quiet", bus.req_done, 0);
        chk("busy", bus.busy, cmd_q.size() > 0 || done_q.size() > 0);
        chk("rsp_ready", bus.rsp_ready, cmd_q.size() == 0 && done_q.size() > 0);
        if (cmd_q.size() > 0) begin
            mc = cmd_q[0];
            chk("cmd_valid", bus.cmd_valid, 1);
            chk("cmd_write", bus.cmd_write, mc.w);
            chk("cmd_addr", bus.cmd_addr, mc.a);
            chk("cmd_wdata", bus.cmd_wdata, mc.d);
            chk("cmd_wstrb", bus.cmd_wstrb, mc.s);
            if (bus.cmd_ready) begin
                md = $urandom_range(0, TO + 3);
                r_data = $urandom;
                r_resp = 2'($urandom);
                rsp_at = md < TO ? cyc + 1 + md : -1;
                me.who = mc.who;
                me.d = md < TO ? r_data : 32'h0;
                me.r = md < TO ? r_resp : 2'b10;
                me.cyc = cyc + 2 + (md < TO ? md : TO - 1);
                void'(cmd_q.pop_front());
                done_q.push_back(me);
            end
        end else chk("cmd_valid_quiet", bus.cmd_valid, 0);
        mg = (cmd_q.size() > 0 || done_q.size() > 0) ? -1 : pick(bus.req_valid, last);
        chk("req_ack", bus.req_ack, mg < 0 ? '0 : NR'(1) << mg);
        if (mg >= 0) begin
            last = mg;
            acked[mg] = 1;
            cmd_q.push_back('{who: mg, w: t_w[mg], a: t_a[mg], d: t_d[mg], s: t_s[mg]});
        end
    end

    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_resp = '0;
        for (int i = 0; i < NR; i++) acked[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;
        run = 1;
        gen = 1;
        repeat (1500) begin
            @(posedge clk);
            #1;
            drive();
        end
        n = 0;
        while (!bus.rsp_ready && n < 200) begin
            @(posedge clk);
            #1;
            drive();
            n++;
        end
        chk("reach_wait_rsp", bus.rsp_ready, 1);
        run = 0;
        rsp_at = -1;
        bus.rsp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        for (int i = 0; i < NR; i++) new_txn(i);
        #1;
        chk("reset_ack_gated", bus.req_ack, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_no_done", bus.req_done, 0);
        cmd_q.delete();
        done_q.delete();
        last = NR - 1;
        for (int i = 0; i < NR; i++) acked[i] = 0;
        rst_n = 1'b1;
        #1;
        chk("post_reset_prio0", bus.req_ack, 4'b0001);
        run = 1;
        repeat (600) begin
            @(posedge clk);
            #1;
            drive();
        end
        gen = 0;
        n = 0;
        while ((bus.req_valid != 0 || cmd_q.size() > 0 || done_q.size() > 0) && n < 400) begin
            @(posedge clk);
            #1;
            drive();
            n++;
        end
        chk("drain_done", n < 400, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("stray_clear", bus.stray_rsp, 0);
        bus.rsp_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_valid = 1'b0;
        chk("stray_set", bus.stray_rsp, 1);
        chk("stray_no_ready", bus.rsp_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("stray_sticky", bus.stray_rsp, 1);
        run = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi4_lite_rr_arbiter.md
Name: axi4_lite_rr_arbiter

Overview:
Shares one AXI4-Lite master between NUM_REQ independent requesters. The block sits upstream of the master's command/response port. It picks one requester with round-robin arbitration and latches that requester's command. It then drives the command to the master, waits for the response and routes the result back to the winning requester. Only one transaction is outstanding at a time, and a response timeout prevents a stuck slave from locking out all requesters.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADDRESS, 32, address width
DATA_WIDTH, 32, data width (32 only; WSTRB is 4 bits)
TIMEOUT, 256, max cycles in WAIT_RSP before forced completion; 0 disables the timeout

Ports:
ACLK  in  1  clock; all logic on posedge
ARESETN  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request; held until req_ack
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDRESS  flattened addresses; requester i at [i*ADDRESS +: ADDRESS]
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
req_wstrb  in  NUM_REQ*4  flattened byte strobes
req_ack  out  NUM_REQ  one-hot; command accepted this cycle
req_done  out  NUM_REQ  one-hot one-cycle completion pulse
req_rdata  out  DATA_WIDTH  read data, valid with req_done
req_resp  out  2  AXI response, valid with req_done
cmd_valid  out  1  command to master valid
cmd_ready  in  1  master accepts command
cmd_write  out  1  latched direction
cmd_addr  out  ADDRESS  latched address
cmd_wdata  out  DATA_WIDTH  latched write data
cmd_wstrb  out  4  latched strobes
rsp_valid  in  1  master response valid
rsp_ready  out  1  arbiter accepts response
rsp_rdata  in  DATA_WIDTH  read data from master
rsp_resp  in  2  RRESP/BRESP from master
busy  out  1  state != IDLE
stray_rsp  out  1  sticky: rsp_valid seen outside WAIT_RSP

Behaviour:
- Reset values: state IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first. All outputs are 0, including latched cmd_* fields, req_rdata, req_resp, stray_rsp and the timeout counter.
- States:
  - IDLE: if any req_valid, the winner g is the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ. req_ack[g] is asserted combinationally in that cycle. At the clock edge the block latches g, write, addr, wdata and wstrb, then goes to ISSUE. With no request it stays in IDLE.
  - ISSUE: cmd_valid=1 and the latched fields are stable. When cmd_ready=1 at an edge, go to WAIT_RSP and clear the counter. cmd_valid does not drop before cmd_ready.
  - WAIT_RSP: rsp_ready=1 and the counter increments each cycle.
    - If rsp_valid=1 at an edge: register req_done[g]=1, req_rdata=rsp_rdata and req_resp=rsp_resp; set pointer=g; go to IDLE.
    - Else if TIMEOUT!=0 and the counter reaches TIMEOUT-1: complete the same way with req_resp=2'b10 (SLVERR) and req_rdata=0.
- Latency: req_done is seen the cycle after the response edge, which is the same cycle the FSM is back in IDLE. Minimum cycle from req_ack to req_done is 3 (ack, ISSUE with cmd_ready=1, WAIT_RSP with rsp_valid=1, done).
- req_done, req_rdata and req_resp are valid for exactly one cycle. req_done returns to 0 the next cycle; rdata and resp hold their values.
- Fairness: a requester that keeps req_valid asserted cannot win twice while another requester is waiting. Order is strictly rotational.
- A req_valid deasserted before ack is simply not granted; no error.
- Simultaneous events: a new ack can occur in the same cycle req_done pulses, because the FSM is in IDLE.
- rsp_valid while in IDLE or ISSUE is dropped (rsp_ready=0) and sets stray_rsp. stray_rsp clears only on reset.
- Reset mid-transaction: return immediately to the reset values. No done pulse is issued for the aborted request.
- Counter width: $clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Package axi4_lite_pkg: arb_state_t enum {IDLE, ISSUE, WAIT_RSP}; AXI response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- Sub-module rr_picker: combinational; inputs are the request vector and the pointer; output is the one-hot grant plus an any-request flag. It is reusable elsewhere.

Test Plan:
- Single read: NUM_REQ=4, req_valid=4'b0100, addr 0x10, cmd_ready and rsp_valid each asserted 1 cycle after entry, rsp_rdata=0xDEADBEEF, resp 0 -> req_ack=4'b0100; cmd_addr=0x10, cmd_write=0; req_done=4'b0100 with rdata 0xDEADBEEF, resp 00.
- Round-robin: all four req_valid held continuously, master responds immediately -> grant order 0,1,2,3,0,1; each req_done is one-hot and matches the preceding ack.
- Backpressure: cmd_ready low for 5 cycles -> cmd_valid stays 1 with stable cmd_* values; WAIT_RSP entered only after cmd_ready.
- Timeout: TIMEOUT=8, no rsp_valid -> req_done 8 cycles after entering WAIT_RSP with resp=2'b10 and rdata=0. A later rsp_valid in IDLE sets stray_rsp=1.
- Write passthrough: req 1 writes 0x0000_00A5 to 0x24 with wstrb 4'b0001 and rsp_resp=2'b00 -> cmd fields match exactly; done on requester 1 only.
- Reset in WAIT_RSP: drop ARESETN -> outputs 0 asynchronously; no req_done; after release, requester 0 has priority.
